// File: rtl/trace_pkg.sv
// Shared FSM encoding and source-tag sizing for the trace capture controller.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int TILE_NUM_DEF = 4;

  // Index width for a source count; floor of 1 keeps vectors legal for tiny counts.
  function automatic int tag_width(input int tile_num);
    return (tile_num > 1) ? $clog2(tile_num) : 1;
  endfunction

  localparam int TAGW = tag_width(TILE_NUM_DEF);

endpackage

// File: rtl/trace_rr_arbiter.sv
// Round-robin arbiter over req & mask; search begins one past the last grant.
// Grant is combinational; pointer moves on the edge after a grant; no backpressure.
module trace_rr_arbiter
  import trace_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            mask,
  input  logic                    en,
  output logic [N-1:0]            gnt,
  output logic [tag_width(N)-1:0] gnt_idx
);

  localparam int PW = tag_width(N);

  logic [N-1:0]  qual;
  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;

  assign qual = req & mask & {N{en}};

  // Walk from the far end so the candidate closest to ptr is assigned last and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (qual[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture: arbitrates sources into a trace buffer around a stop trigger, then reads it out.
// Writes/read strobes land one cycle after grant/request; no backpressure. TRACE_SRC_TAG_EN tags tb_din.
module trace_capture_ctrl
  import trace_pkg::*;
#(
  parameter int Fpay     = 32,
  parameter int Tile_num = 4,
  parameter int TB_AW    = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [Tile_num-1:0]      src_req,
  input  logic [Tile_num*Fpay-1:0] src_din,
  input  logic [Tile_num-1:0]      src_mask,
  input  logic                     arm,
  input  logic                     stop,
  input  logic [TB_AW-1:0]         post_len,
  input  logic                     rd_req,
  output logic [Tile_num-1:0]      src_gnt,
  output logic                     tb_wr_en,
  output logic [Fpay-1:0]          tb_din,
  output logic                     tb_rd_en,
  output logic                     rd_valid,
  output logic [1:0]               state,
  output logic                     wrapped,
  output logic [TB_AW:0]           word_cnt
);

  localparam int TAG_W = tag_width(Tile_num);
  localparam int CW    = TB_AW + 1;
  localparam logic [CW-1:0] FULL = {1'b1, {TB_AW{1'b0}}};

  state_t           st;
  logic [TB_AW-1:0] post_len_q;
  logic [CW-1:0]    post_cnt;
  logic [CW-1:0]    post_seen;
  logic             wr_post;
  logic             gnt_en;
  logic             rd_ok;
  logic             arm_ok;
  logic [TAG_W-1:0] gnt_idx;
  logic [Fpay-1:0]  gnt_word;
  logic [Fpay-1:0]  wr_dat;

  // post_seen = post-trigger grants already issued, including one whose write is in flight.
  assign post_seen = post_cnt + CW'(tb_wr_en & wr_post);
  assign gnt_en    = (st == ARMED) || ((st == POST) && (post_seen < {1'b0, post_len_q}));
  assign rd_ok     = (st == DONE) && rd_req && (word_cnt != '0);
  assign arm_ok    = arm && ((st == IDLE) || (st == DONE));
  assign state     = st;

  trace_rr_arbiter #(
    .N (Tile_num)
  ) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_req),
    .mask    (src_mask),
    .en      (gnt_en),
    .gnt     (src_gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    gnt_word = '0;
    for (int i = 0; i < Tile_num; i++) begin
      if (src_gnt[i]) gnt_word = src_din[i*Fpay +: Fpay];
    end
  end

`ifdef TRACE_SRC_TAG_EN
  assign wr_dat = {gnt_idx, gnt_word[Fpay-TAG_W-1:0]};
`else
  assign wr_dat = gnt_word;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= IDLE;
      post_len_q <= '0;
      post_cnt   <= '0;
      wr_post    <= 1'b0;
      tb_wr_en   <= 1'b0;
      tb_din     <= '0;
      tb_rd_en   <= 1'b0;
      rd_valid   <= 1'b0;
      wrapped    <= 1'b0;
      word_cnt   <= '0;
    end else begin
      tb_wr_en <= |src_gnt;
      wr_post  <= (|src_gnt) && (st == POST);
      if (|src_gnt) tb_din <= wr_dat;
      tb_rd_en <= rd_ok;
      rd_valid <= tb_rd_en;

      unique case (st)
        IDLE:  if (arm) st <= ARMED;
        ARMED: begin
          if (stop) begin
            st         <= POST;
            post_cnt   <= '0;
            post_len_q <= post_len;
          end
        end
        POST: begin
          post_cnt <= post_seen;
          if (post_seen == {1'b0, post_len_q}) st <= DONE;
        end
        DONE:  if (arm) st <= ARMED;
      endcase

      if (arm_ok) begin
        word_cnt <= '0;
        wrapped  <= 1'b0;
      end else begin
        if (tb_wr_en && (word_cnt == FULL)) wrapped <= 1'b1;
        if (rd_ok) begin
          word_cnt <= word_cnt - CW'(1);
        end else if (tb_wr_en && (word_cnt != FULL)) begin
          word_cnt <= word_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed bench for trace_capture_ctrl with a cycle model checked every cycle.
module tb_trace_capture_ctrl;

  localparam int FP  = 32;
  localparam int TN  = 4;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic              clk = 1'b0;
  logic              reset;
  logic [TN-1:0]     src_req;
  logic [TN*FP-1:0]  src_din;
  logic [TN-1:0]     src_mask;
  logic              arm;
  logic              stop;
  logic [AW-1:0]     post_len;
  logic              rd_req;
  logic [TN-1:0]     src_gnt;
  logic              tb_wr_en;
  logic [FP-1:0]     tb_din;
  logic              tb_rd_en;
  logic              rd_valid;
  logic [1:0]        state;
  logic              wrapped;
  logic [AW:0]       word_cnt;

  trace_capture_ctrl #(
    .Fpay     (FP),
    .Tile_num (TN),
    .TB_AW    (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src_req  (src_req),
    .src_din  (src_din),
    .src_mask (src_mask),
    .arm      (arm),
    .stop     (stop),
    .post_len (post_len),
    .rd_req   (rd_req),
    .src_gnt  (src_gnt),
    .tb_wr_en (tb_wr_en),
    .tb_din   (tb_din),
    .tb_rd_en (tb_rd_en),
    .rd_valid (rd_valid),
    .state    (state),
    .wrapped  (wrapped),
    .word_cnt (word_cnt)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  bit            m_ok = 1'b0;
  int            m_state, m_last, m_rem, m_words;
  bit            m_wr, m_rd, m_rv, m_wrapped;
  logic [FP-1:0] m_din;

  int n_wr = 0, n_rd = 0, n_rv = 0;
  int gq[$];

  int s1_exp[5] = '{0, 1, 2, 3, 0};
  int s2_exp[6] = '{2, 0, 2, 0, 2, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [TN-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < TN; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Model: outputs follow from the capture rules, advanced once per cycle at the negedge.
  task automatic model_cycle();
    logic [TN-1:0] exp_gnt;
    int            g;
    int            nstate;
    bit            rd_go;
    bit            eligible;
    exp_gnt  = '0;
    g        = -1;
    eligible = (m_state == 1) || ((m_state == 2) && (m_rem > 0));
    if (m_ok && eligible) begin
      for (int k = 1; k <= TN; k++) begin
        if (g < 0 && src_req[(m_last + k) % TN] && src_mask[(m_last + k) % TN]) g = (m_last + k) % TN;
      end
    end
    if (g >= 0) exp_gnt[g] = 1'b1;

    if (m_ok) begin
      chk("src_gnt", src_gnt, exp_gnt);
      chk("state", state, m_state);
      chk("tb_wr_en", tb_wr_en, m_wr);
      if (m_wr) chk("tb_din", tb_din, m_din);
      chk("tb_rd_en", tb_rd_en, m_rd);
      chk("rd_valid", rd_valid, m_rv);
      chk("word_cnt", word_cnt, m_words);
      chk("wrapped", wrapped, m_wrapped);
      if (tb_wr_en) n_wr++;
      if (tb_rd_en) n_rd++;
      if (rd_valid) n_rv++;
      if (|src_gnt) gq.push_back(oh_idx(src_gnt));
    end

    if (reset) begin
      m_ok = 1'b1; m_state = 0; m_last = TN - 1; m_rem = 0; m_words = 0;
      m_wr = 1'b0; m_rd = 1'b0; m_rv = 1'b0; m_wrapped = 1'b0; m_din = '0;
    end else if (m_ok) begin
      nstate = m_state;
      rd_go  = (m_state == 3) && rd_req && (m_words > 0);
      m_rv   = m_rd;
      m_rd   = rd_go;
      if (m_wr) begin
        if (m_words == CAP) m_wrapped = 1'b1;
        else m_words++;
      end
      if (rd_go) m_words--;
      case (m_state)
        0: if (arm) nstate = 1;
        1: if (stop) begin nstate = 2; m_rem = int'(post_len); end
        2: if (m_rem == 0) nstate = 3;
        default: if (arm) nstate = 1;
      endcase
      if ((m_state == 0 || m_state == 3) && arm) begin
        m_words   = 0;
        m_wrapped = 1'b0;
      end
      m_wr = (g >= 0);
      if (g >= 0) begin
        m_din = src_din[g*FP +: FP];
`ifdef TRACE_SRC_TAG_EN
        m_din[FP-1 -: 2] = 2'(g);
`endif
        m_last = g;
        if (m_state == 2) m_rem--;
      end
      m_state = nstate;
    end
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bw, bq, br, bv;
    reset    = 1'b1;
    src_req  = '0;
    src_mask = 4'hF;
    src_din  = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    arm      = 1'b0;
    stop     = 1'b0;
    post_len = '0;
    rd_req   = 1'b0;
    tick(3);
    chk("rst_state", state, 0);
    chk("rst_gnt", src_gnt, 0);
    chk("rst_din", tb_din, 0);
    chk("rst_cnt", word_cnt, 0);
    reset = 1'b0;

    // Continuous requests: rotation 0,1,2,3,0
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("armed", state, 1);
    bw = n_wr; bq = gq.size();
    src_req = 4'hF; tick(5); src_req = '0; tick(1);
    chk("s1_writes", n_wr - bw, 5);
    chk("s1_ngnt", gq.size() - bq, 5);
    for (int k = 0; k < 5; k++) chk("s1_order", gq[bq + k], s1_exp[k]);

    // Mask 0101: only sources 0 and 2
    bw = n_wr; bq = gq.size();
    src_mask = 4'b0101; src_req = 4'hF; tick(6); src_req = '0; tick(1);
    src_mask = 4'hF;
    chk("s2_writes", n_wr - bw, 6);
    for (int k = 0; k < 6; k++) chk("s2_order", gq[bq + k], s2_exp[k]);
    chk("s2_cnt", word_cnt, 11);

    // post_len=0: DONE next cycle, no post writes; stop in DONE ignored
    bw = n_wr;
    stop = 1'b1; post_len = 0; tick(1); stop = 1'b0;
    chk("pl0_post", state, 2);
    tick(1);
    chk("pl0_done", state, 3);
    chk("pl0_writes", n_wr - bw, 0);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("stop_in_done", state, 3);

    // 10 pre-trigger writes (last on the stop cycle) + 3 post writes
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("rearm_cnt", word_cnt, 0);
    bw = n_wr;
    src_req = 4'hF; tick(4);
    arm = 1'b1; tick(1); arm = 1'b0;
    chk("arm_in_armed", state, 1);
    tick(4);
    stop = 1'b1; post_len = 3; tick(1); stop = 1'b0;
    for (int k = 0; k < 20 && state != 2'd3; k++) tick(1);
    chk("s3_done", state, 3);
    src_req = '0; tick(1);
    chk("s3_writes", n_wr - bw, 13);
    chk("s3_cnt", word_cnt, 13);

    // Two words held, three reads requested
    arm = 1'b1; tick(1); arm = 1'b0;
    src_req = 4'b0001; tick(2); src_req = '0;
    stop = 1'b1; post_len = 0; tick(1); stop = 1'b0; tick(2);
    chk("s5_done", state, 3);
    chk("s5_cnt", word_cnt, 2);
    br = n_rd; bv = n_rv;
    rd_req = 1'b1; tick(3); rd_req = 1'b0; tick(3);
    chk("s5_rd", n_rd - br, 2);
    chk("s5_rv", n_rv - bv, 2);
    chk("s5_cnt0", word_cnt, 0);

    // Saturation and wrap
    arm = 1'b1; tick(1); arm = 1'b0;
    src_req = 4'hF; tick(16); src_req = '0; tick(1);
    chk("s4_full", word_cnt, 16);
    chk("s4_nowrap", wrapped, 0);
    src_req = 4'hF; tick(4); src_req = '0; tick(1);
    chk("s4_sat", word_cnt, 16);
    chk("s4_wrap", wrapped, 1);

    // Reset in POST with a write in flight
    src_req = 4'hF; stop = 1'b1; post_len = 15; tick(1); stop = 1'b0; tick(3);
    chk("s6_post", state, 2);
    chk("s6_inflight", tb_wr_en, 1);
    reset = 1'b1; tick(1);
    chk("s6_state", state, 0);
    chk("s6_gnt", src_gnt, 0);
    chk("s6_wr", tb_wr_en, 0);
    chk("s6_din", tb_din, 0);
    chk("s6_rd", tb_rd_en, 0);
    chk("s6_rv", rd_valid, 0);
    chk("s6_wrap", wrapped, 0);
    chk("s6_cnt", word_cnt, 0);
    reset = 1'b0; src_req = '0; tick(2);

    // Pointer restarts at source 0 after reset
    arm = 1'b1; tick(1); arm = 1'b0;
    bq = gq.size();
    src_req = 4'hF; tick(1); src_req = '0; tick(1);
    chk("ptr_rst_n", gq.size() - bq, 1);
    chk("ptr_rst", gq[bq], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
TRACE_CAPTURE_CTRL -- requirements
Module: trace_capture_ctrl

Interface
REQ-001 Parameter Fpay, default 32: trace word width in bits.
REQ-002 Parameter Tile_num, default 4: number of trace sources; legal range 2..16.
REQ-003 Parameter TB_AW, default 9: trace buffer address width; buffer holds 2^TB_AW words.
REQ-004 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high, port name reset.
REQ-005 Ports, as name  direction  width  meaning:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- src_req  in  Tile_num  per-source write request.
- src_din  in  Tile_num*Fpay  packed source data; source i at [i*Fpay +: Fpay].
- src_mask  in  Tile_num  source enable; masked sources are never granted.
- arm  in  1  start-capture pulse.
- stop  in  1  trigger; begins post-trigger phase.
- post_len  in  TB_AW  number of words written after the trigger.
- rd_req  in  1  readout request pulse.
- src_gnt  out  Tile_num  one-hot grant, combinational.
- tb_wr_en  out  1  buffer write strobe.
- tb_din  out  Fpay  buffer write data.
- tb_rd_en  out  1  buffer read strobe.
- rd_valid  out  1  buffer read data valid.
- state  out  2  FSM state.
- wrapped  out  1  sticky; buffer has overwritten old data.
- word_cnt  out  TB_AW+1  valid words held, saturating at 2^TB_AW.

Function
REQ-006 FSM states: IDLE=0, ARMED=1, POST=2, DONE=3.
REQ-007 IDLE->ARMED on arm; ARMED->POST on stop; POST->DONE when the post counter reaches post_len; DONE->ARMED on arm; all other conditions hold the state.
REQ-008 stop in IDLE or DONE SHALL be ignored; arm in ARMED or POST SHALL be ignored.
REQ-009 post_len is sampled on the ARMED->POST transition; post_len=0 SHALL go POST->DONE on the next cycle with no post writes.
REQ-010 Arbitration: round-robin over src_req & src_mask, starting one past the last granted index; src_gnt is all-zero outside ARMED/POST or when no source qualifies.
REQ-011 Each grant in cycle n SHALL produce tb_wr_en=1 and the granted data on tb_din in cycle n+1 (registered, 1-cycle latency).
REQ-012 Each tb_wr_en pulse in POST SHALL increment the post counter; a write granted on the stop cycle counts as a pre-trigger write.
REQ-013 word_cnt increments per write and saturates at 2^TB_AW; wrapped is set on the first write made while word_cnt=2^TB_AW.
REQ-014 In DONE, rd_req SHALL give tb_rd_en=1 in the next cycle and rd_valid=1 one cycle after that; rd_req with word_cnt=0 SHALL be ignored.
REQ-015 Each read decrements word_cnt; back-to-back rd_req SHALL sustain one read per cycle.
REQ-016 arm from DONE clears word_cnt and wrapped in the same cycle that ARMED is entered.

Reset
REQ-017 Reset gives state=IDLE, src_gnt=0, tb_wr_en=0, tb_din=0, tb_rd_en=0, rd_valid=0, wrapped=0, word_cnt=0, and round-robin pointer=0.
REQ-018 Reset during any state SHALL abort the operation and discard in-flight write and read strobes.

Configuration
REQ-019 Macro TRACE_SRC_TAG_EN: when defined, tb_din[Fpay-1 -: TAGW] SHALL carry the granted source index, and the remaining bits carry the low bits of src_din. When the macro is not defined, tb_din SHALL carry the full src_din word.

Structure
REQ-020 Package trace_pkg SHALL hold the state enum, the state encodings and TAGW = $clog2(Tile_num).
REQ-021 Sub-module trace_rr_arbiter holds the round-robin request mask and pointer logic.

Verification
REQ-022 The bench SHALL cover these scenarios:
- All 4 sources requesting continuously in ARMED -> grant order 0,1,2,3,0, with tb_wr_en every cycle after the first.
- src_mask=4'b0101 with all requests active -> grants alternate between source 0 and source 2; no tb_din from source 1 or 3.
- arm, 10 writes, stop with post_len=3 -> exactly 3 further tb_wr_en pulses, then state=DONE and word_cnt=13.
- TB_AW=4 with 20 writes -> word_cnt=16 and wrapped=1 from the 17th write onward.
- In DONE with word_cnt=2, three rd_req pulses -> two tb_rd_en pulses, rd_valid one cycle after each, and word_cnt=0.
- Reset asserted in POST -> the next cycle shows state=IDLE, with all outputs at their reset values.
